// File: rtl/ram_copy_engine.sv
// Copies a run of words from one region of a single-port RAM to another,
// using one read/wait/write triple per word.
module ram_copy_engine #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] src_addr_i,
  input  logic [AWIDTH-1:0] dst_addr_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [AWIDTH:0]   words_done,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  input  logic              ram_valid
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

  localparam logic [AWIDTH-1:0] PTR_ONE = 1;
  localparam logic [AWIDTH:0]   CNT_ONE = 1;

  state_t            state, state_next;
  logic [AWIDTH-1:0] src_ptr, dst_ptr;
  logic [AWIDTH:0]   len_reg;
  logic [DWIDTH-1:0] data_reg;
  logic              active;

  always_comb begin
    state_next = state;
    active     = (state == RD) || (state == WAIT) || (state == WR);
    case (state)
      IDLE: if (start) state_next = (len_i == '0) ? FIN : RD;
      RD:   state_next = abort ? IDLE : WAIT;
      WAIT: begin
        if (abort)          state_next = IDLE;
        else if (ram_valid) state_next = WR;
      end
      WR: begin
        // The write in this cycle still lands even when abort is raised
        if (abort)                           state_next = IDLE;
        else if (words_done + CNT_ONE < len_reg) state_next = RD;
        else                                 state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-side pins depend only on registered state, so no input reaches them combinationally
  always_comb begin
    busy      = active;
    done      = (state == FIN);
    ram_en    = (state == RD) || (state == WR);
    ram_wen   = (state == WR);
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == RD) ram_addr = src_ptr;
    if (state == WR) begin
      ram_addr  = dst_ptr;
      ram_wdata = data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      len_reg    <= '0;
      data_reg   <= '0;
      words_done <= '0;
      aborted    <= 1'b0;
    end else begin
      state   <= state_next;
      aborted <= abort && active;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr    <= src_addr_i;
            dst_ptr    <= dst_addr_i;
            len_reg    <= len_i;
            words_done <= '0;
          end
        end
        WAIT: if (ram_valid) data_reg <= ram_rdata;
        WR: begin
          src_ptr    <= src_ptr + PTR_ONE;
          dst_ptr    <= dst_ptr + PTR_ONE;
          words_done <= words_done + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Sequencer sitting directly upstream of the single-port RAM.
- Drives the RAM's enable, write-enable, address and write-data pins, and consumes its read data and valid.
- On a start command it copies LEN words from a source address range to a destination range in the same RAM, one word per read/wait/write triple.
- Used for memory initialisation moves and buffer relocation without CPU involvement.

Parameters:
- DWIDTH, 16, data word width; must match the RAM.
- AWIDTH, 16, address width; must match the RAM. The address space is 2^AWIDTH words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high, sampled on the clk rising edge.
- start  input  1  one-cycle command strobe, sampled only in IDLE.
- abort  input  1  cancels an in-progress copy.
- src_addr_i  input  AWIDTH  first source word address, latched on start.
- dst_addr_i  input  AWIDTH  first destination word address, latched on start.
- len_i  input  AWIDTH+1  word count, latched on start; range 0 .. 2^AWIDTH.
- busy  output  1  high while a copy is in progress.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when a copy is cancelled.
- words_done  output  AWIDTH+1  count of words written in the current or last copy.
- ram_en  output  1  RAM enable.
- ram_wen  output  1  RAM write enable.
- ram_addr  output  AWIDTH  RAM address.
- ram_wdata  output  DWIDTH  RAM write data.
- ram_rdata  input  DWIDTH  RAM registered read data.
- ram_valid  input  1  RAM valid flag; high in the cycle after any enabled access.

Behaviour:
- Reset: state=IDLE. busy, done, aborted, ram_en, ram_wen = 0. ram_addr, ram_wdata, words_done = 0. Reset overrides start and abort in the same cycle.
- RAM contract: the RAM captures the access on the edge where ram_en=1. Read data and ram_valid appear in the following cycle.
- RAM-side outputs are decoded from registered state, pointers and the data register only; they carry no combinational path from inputs.
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - start=1 and len_i>0: latch src/dst/len, clear words_done, go to RD.
  - start=1 and len_i=0: go to FIN (done pulse, nothing written, words_done=0).
  - start=0: stay; ram_en=0.
- RD: ram_en=1, ram_wen=0, ram_addr=src_ptr. Go to WAIT.
- WAIT:
  - ram_en=0.
  - ram_valid=1: capture ram_rdata into the data register, go to WR.
  - ram_valid=0: stay in WAIT indefinitely; this tolerates a slower memory.
- WR:
  - ram_en=1, ram_wen=1, ram_addr=dst_ptr, ram_wdata=data register.
  - Increment src_ptr, dst_ptr and words_done.
  - Go to RD if words_done+1 < len, else go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RD, WAIT and WR; busy=0 in IDLE and FIN.
- Pointer arithmetic is modulo 2^AWIDTH: 0xFFFF+1 wraps to 0x0000 for AWIDTH=16.
- len=2^AWIDTH is legal and copies the whole space.
- Overlapping ranges are copied forward word by word with no overlap protection. With dst > src and overlap, source words are overwritten before they are read; this is intended and documented.
- Timing: start sampled on edge 0; first RD in cycle 1; N words complete after 3N cycles; done in cycle 3N+1; IDLE in cycle 3N+2. This holds when ram_valid returns on time.
- start while busy is ignored; it is not queued.
- abort=1 in RD, WAIT or WR:
  - Next state is IDLE; ram_en=0 from the next cycle.
  - aborted pulses for one cycle in that next cycle; done is not pulsed.
  - words_done holds the number of writes already issued.
  - A write issued in the same cycle as abort still completes at the RAM and is counted.
- abort in IDLE or FIN has no effect.
- start and abort together in IDLE: start wins.
- done and aborted are never high together.

Test Plan:
- Preload RAM[0x10..0x13] = 0xA1,0xA2,0xA3,0xA4; start with src=0x10, dst=0x40, len=4 → RAM[0x40..0x43] = same values; busy for 12 cycles; done in cycle 13; words_done=4.
- start with len=0 → no ram_en ever asserted; done pulse in cycle 1; busy stays 0.
- Preload RAM[0xFFFE]=0x1111 and RAM[0xFFFF]=0x2222; start with src=0xFFFE, dst=0x0100, len=3 → reads 0xFFFE, 0xFFFF, 0x0000 in that order; RAM[0x0100..0x0102] = 0x1111, 0x2222, old RAM[0]; done pulse.
- Start with len=8, raise abort in the WR cycle of word 3 → aborted pulse next cycle; no done; words_done=3; RAM[dst+3..dst+7] unchanged.
- Second start issued while busy → ignored; the original copy completes with the original len; exactly one done pulse.
- Assert rst mid-copy in the WAIT state → next cycle all outputs are zero and state is IDLE; a new start then completes normally.
